switch_debounce: RTL and testbench
==================================

# switch_debounce

Synchronises and debounces raw slide-switch inputs from the DE10-Standard board pins. Produces clean, stable levels that feed the `in_port` of the Nios II switch-select PIO. Each bit has a two-flop synchroniser and an independent debounce state machine with a terminal-count counter. Optional single-cycle edge pulses let fabric logic react to switch changes without polling through Avalon.

## Interface
Parameters:
- `WIDTH`, 1: number of switch bits; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronised samples required to accept a new level (1 ms at 50 MHz). Legal range is 2 or more.

Ports:
- `clk`  in  1: system clock, the same clock as the PIO.
- `reset`  in  1: asynchronous, active-high reset.
- `sw_in`  in  WIDTH: raw, asynchronous switch pins.
- `sw_out`  out  WIDTH: debounced level; connects to the PIO `in_port`.
- `sw_rise`  out  WIDTH: one-cycle pulse when `sw_out[i]` goes 0→1.
- `sw_fall`  out  WIDTH: one-cycle pulse when `sw_out[i]` goes 1→0.

## Operation
- **Synchroniser:** `s1 <= sw_in` and `s2 <= s1`, every bit, every cycle. Only `s2` is used downstream.
- **Per-bit FSM states:** `STABLE` and `CHECK`. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **In `STABLE`:**
  - If `s2 != sw_out`: go to `CHECK`, set `cnt <= 1`.
  - Otherwise: hold, with `cnt = 0`.
- **In `CHECK`:**
  - If `s2 == sw_out` (glitch ended): go to `STABLE`, set `cnt <= 0`. `sw_out` is unchanged.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: set `sw_out <= s2`, go to `STABLE`, set `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Acceptance rule:** a new level is accepted only after exactly `DEBOUNCE_CYCLES` consecutive differing `s2` samples. Any single matching sample restarts the qualification.
- **Edge pulses:**
  - `sw_rise[i]` / `sw_fall[i]` are registered and asserted in the same cycle that `sw_out[i]` first shows its new value.
  - Each pulse lasts exactly one cycle.
  - Rise and fall are never asserted together on the same bit.
- **Bit independence:** bits are fully independent. Simultaneous transitions on several bits each follow their own FSM.
- **Reset (async, any time including mid-`CHECK`):**
  - `s1`, `s2`, `sw_out`, `sw_rise`, `sw_fall`, and every `cnt` clear to 0.
  - All FSMs return to `STABLE`.
  - Any in-progress qualification is discarded.
- **Power-up with a switch already high:** a normal qualified rise occurs after reset release, and `sw_rise` pulses once.

## Timing
- Let E0 be the first rising edge at which a new `sw_in` level is sampled into `s1`, with the level held stable from then on.
- `s2` reflects the new level at E0+1.
- `sw_out` updates at edge E0+`DEBOUNCE_CYCLES`+1. Example: `DEBOUNCE_CYCLES`=4 gives an update at E0+5.
- Edge pulses are coincident with the `sw_out` update.
- A level held for fewer than `DEBOUNCE_CYCLES` sampled cycles never reaches `sw_out`.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- The first sampling edge is the first rising `clk` after `reset` deasserts.
- The PIO adds one further register stage on its Avalon read path, so software sees a change at `sw_out` one cycle later.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_EN`.
- **Defined:** edge-detect registers are built and `sw_rise` / `sw_fall` behave as specified.
- **Undefined:** no edge logic is synthesised. `sw_rise` and `sw_fall` are tied to 0 constantly, the ports remain present, and `sw_out` behaviour is identical.

## Structure
- **Package `switch_debounce_pkg`:**
  - FSM state enum `db_state_t` (`STABLE`, `CHECK`).
  - Default constant `DB_CYCLES_1MS_50MHZ = 50000`.
- **Sub-module `debounce_bit`:**
  - Holds the single-bit synchroniser, FSM, counter and edge registers.
  - Instantiated `WIDTH` times in a generate loop by `switch_debounce`.

## Test plan
- **Reset values:** assert `reset` mid-simulation with `sw_in`=1 → `sw_out`, `sw_rise` and `sw_fall` are all 0 immediately (asynchronously).
- **Clean rise:** `DEBOUNCE_CYCLES`=4, `sw_in` 0→1 sampled at E0 and held → `sw_out`=1 and `sw_rise`=1 at E0+5; `sw_rise`=0 at E0+6.
- **Glitch rejection:** `DEBOUNCE_CYCLES`=4, `sw_in` high for 3 cycles then low → `sw_out` stays 0, no pulses, FSM back in `STABLE`.
- **Bounce restart:** `sw_in` toggles 1,1,0,1,1,1,1 → `sw_out` rises only 4 cycles after the final run of 1s enters `s2`.
- **Multi-bit and reset mid-`CHECK`:**
  - `WIDTH`=2, bit0 rises while bit1 falls concurrently → independent, correctly timed pulses on each bit.
  - `reset` pulsed at `cnt`=2 → qualification restarts from 0 after release.
- **Macro off:** compile without `SWITCH_DEBOUNCE_EDGE_EN` and repeat the clean-rise scenario → identical `sw_out`, while `sw_rise` and `sw_fall` remain 0.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
package switch_debounce_pkg;

  // Per-bit debounce FSM states
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_t;

  // 1 ms at 50 MHz
  localparam int DB_CYCLES_1MS_50MHZ = 50000;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser + debounce FSM + optional edge registers.
// Edge pulses are built only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_1MS_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             upd;

  // Two-flop synchroniser; only s2_q is used downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Final qualifying sample: the level is accepted on this edge
  assign upd = (state_q == CHECK) && (s2_q != level_q) && (cnt_q == CNT_LAST);

  // FSM, counter and debounced level registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next state: any matching sample drops back to STABLE and restarts counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE: begin
        if (s2_q != level_q) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (s2_q == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (upd) begin
          level_d = s2_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Edge pulses registered alongside the level so they coincide with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= upd & s2_q;
      fall_q <= upd & ~s2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH raw switch pins into clean levels for the PIO in_port.
// Optional edge pulses: define SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_1MS_50MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  // One fully independent debouncer per switch bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .sw_i    (sw_in[i]),
      .level_o (sw_out[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: WIDTH=2, DEBOUNCE_CYCLES=4, random + directed.
module tb_switch_debounce;

  localparam int W = 2;
  localparam int D = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out, sw_rise, sw_fall;

  int checks = 0;
  int errors = 0;

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  // Reference: sw_in delayed two samples; a level flips once it has been
  // seen differing from the output on D consecutive samples.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  int           run [W];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (m_s2[b] != m_out[b]) begin
          run[b]++;
          if (run[b] == D) begin
            m_out[b]  = m_s2[b];
            m_rise[b] = EDGE & m_s2[b];
            m_fall[b] = EDGE & ~m_s2[b];
            run[b]    = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sw_in = '0;
    #1;
    checks++;
    if ({sw_out, sw_rise, sw_fall} !== '0) begin
      errors++;
      $display("FAIL reset_initial got %b/%b/%b want 0/0/0", sw_out, sw_rise, sw_fall);
    end
    // Bring outputs high, then assert reset between edges
    sw_in = '1;
    reset = 1'b0;
    tick();
    repeat (10) tick();
    checks++;
    if (sw_out !== '1) begin
      errors++;
      $display("FAIL reset_prefill got %b want 11", sw_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sw_out, sw_rise, sw_fall} !== '0) begin
      errors++;
      $display("FAIL reset_async got %b/%b/%b want 0/0/0", sw_out, sw_rise, sw_fall);
    end
  endtask

  // Power-up with switches high: qualified rise 5 edges after release
  task automatic test_powerup_high();
    int n;
    int rises;
    sw_in = '1;
    @(negedge clk) reset = 1'b0;
    n = 0;
    rises = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (sw_rise[0]) rises++;
      if (sw_out[0] && n == 0) n = k;
      checks++;
      if ({sw_out, sw_rise, sw_fall} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL powerup_model k=%0d got %b/%b/%b want %b/%b/%b",
                 k, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (n != 6 || rises != int'(EDGE)) begin
      errors++;
      $display("FAIL powerup_timing edge=%0d rises=%0d want edge=6 rises=%0d", n, rises, EDGE);
    end
  endtask

  // Clean rise on bit0 from a settled-low state
  task automatic test_clean_rise();
    sw_in = '0;
    repeat (12) tick();
    sw_in = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({sw_out, sw_rise, sw_fall} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL clean_model k=%0d got %b/%b/%b want %b/%b/%b",
                 k, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
      end
      if (k == 5) begin
        checks++;
        if (sw_out[0] !== 1'b0) begin
          errors++;
          $display("FAIL clean_early got %b want 0", sw_out[0]);
        end
      end
      if (k == 6) begin
        checks++;
        if (sw_out[0] !== 1'b1 || sw_rise[0] !== EDGE || sw_fall[0] !== 1'b0) begin
          errors++;
          $display("FAIL clean_e0p5 got out=%b rise=%b fall=%b want 1/%b/0",
                   sw_out[0], sw_rise[0], sw_fall[0], EDGE);
        end
      end
      if (k == 7) begin
        checks++;
        if (sw_rise[0] !== 1'b0) begin
          errors++;
          $display("FAIL clean_pulse_len got %b want 0", sw_rise[0]);
        end
      end
    end
  endtask

  // Three-cycle pulse on bit1 never reaches the output
  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    sw_in = 2'b01;
    repeat (10) tick();
    sw_in = 2'b11;
    repeat (3) tick();
    sw_in = 2'b01;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sw_out[1] || sw_rise[1] || sw_fall[1]) seen = 1'b1;
    end
    checks++;
    if (seen || sw_out !== 2'b01) begin
      errors++;
      $display("FAIL glitch got seen=%b out=%b want seen=0 out=01", seen, sw_out);
    end
  endtask

  // Bounce 1,1,0,1,1,1,1 on bit1: rise only on step 9
  task automatic test_bounce();
    bit [6:0] pat;
    int n;
    pat = 7'b1111011;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      sw_in[1] = (k <= 7) ? pat[k-1] : 1'b1;
      tick();
      if (sw_out[1] && n == 0) n = k;
      checks++;
      if ({sw_out, sw_rise, sw_fall} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL bounce_model k=%0d got %b/%b/%b want %b/%b/%b",
                 k, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL bounce_timing got step %0d want 9", n);
    end
  endtask

  // bit0 rises while bit1 falls, then reset in mid-qualification
  task automatic test_multibit_reset();
    int n;
    sw_in = 2'b10;
    repeat (12) tick();
    sw_in = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (sw_out !== 2'b01 || sw_rise !== {1'b0, EDGE} || sw_fall !== {EDGE, 1'b0}) begin
          errors++;
          $display("FAIL multibit got %b/%b/%b want 01/%b/%b",
                   sw_out, sw_rise, sw_fall, {1'b0, EDGE}, {EDGE, 1'b0});
        end
      end
    end
    // Settle at 00, then raise bit0 and reset once cnt has reached 2
    sw_in = 2'b00;
    repeat (12) tick();
    sw_in = 2'b01;
    repeat (4) tick();
    #2 reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw_out[0] && n == 0) n = k;
      checks++;
      if ({sw_out, sw_rise, sw_fall} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL midcheck_model k=%0d got %b/%b/%b want %b/%b/%b",
                 k, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL midcheck_restart got step %0d want 6", n);
    end
  endtask

  // Random per-bit hold lengths straddling the debounce threshold
  task automatic test_random();
    int hold [W];
    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          sw_in[b] = 1'($urandom);
          hold[b]  = int'($urandom_range(1, 8));
        end
        hold[b]--;
      end
      tick();
      checks++;
      if ({sw_out, sw_rise, sw_fall} !== {m_out, m_rise, m_fall}) begin
        errors++;
        $display("FAIL random k=%0d got %b/%b/%b want %b/%b/%b",
                 k, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
      end
      checks++;
      if ((sw_rise & sw_fall) !== '0) begin
        errors++;
        $display("FAIL random_excl k=%0d rise=%b fall=%b", k, sw_rise, sw_fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup_high();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_multibit_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
